stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter N_OUTPUTS, default 2, giving the number of output channels (legal range 2..16).
REQ-002 The block SHALL have parameter DWIDTH, default 8, giving the data width in bits.
REQ-003 Derived width SW = $clog2(N_OUTPUTS) SHALL size every select field.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block accepts the upstream beat this cycle.
REQ-008 in_data  input  DWIDTH  upstream payload.
REQ-009 in_sel  input  SW  destination channel of the upstream beat.
REQ-010 out_valid  output  N_OUTPUTS  per-channel beat present, one-hot or zero.
REQ-011 out_ready  input  N_OUTPUTS  per-channel downstream acceptance.
REQ-012 out_data  output  DWIDTH x N_OUTPUTS  unpacked array, per-channel payload.
REQ-013 drop_pulse  output  1  one-cycle flag: an illegal-select beat was discarded.
REQ-014 drop_count  output  8  saturating count of discarded beats.

Function
REQ-015 A beat SHALL transfer upstream when in_valid && in_ready on a rising edge; downstream channel i when out_valid[i] && out_ready[i].
REQ-016 The block SHALL hold one output register (data, sel) with a two-state FSM: EMPTY, FULL.
REQ-017 EMPTY: in_ready = 1; all out_valid = 0.
REQ-018 FULL: out_valid[held_sel] = 1, all other bits 0; in_ready = out_ready[held_sel].
REQ-019 in_ready SHALL NOT depend combinationally on in_valid, in_data or in_sel.
REQ-020 Legal beat (in_sel < N_OUTPUTS) accepted in EMPTY: register captures in_data/in_sel, next state FULL; out_valid rises the following cycle (latency 1).
REQ-021 FULL with downstream transfer and no legal upstream beat: next state EMPTY.
REQ-022 FULL with downstream transfer and simultaneous legal upstream beat: register reloads, state stays FULL; sustained throughput of one beat per cycle with no bubble.
REQ-023 FULL without downstream transfer: register and state SHALL be held unchanged; in_ready = 0.
REQ-024 out_data[i] SHALL equal the held data for every i (broadcast); only out_valid qualifies it.
REQ-025 Illegal beat (in_sel >= N_OUTPUTS, only possible when N_OUTPUTS is not a power of two) SHALL be accepted whenever in_ready = 1, never loaded, and never asserted on any out_valid.
REQ-026 An accepted illegal beat SHALL set drop_pulse high for exactly the next cycle and increment drop_count by 1, saturating at 255.
REQ-027 An accepted illegal beat in FULL with a downstream transfer SHALL leave the FSM EMPTY next cycle; without a downstream transfer it cannot be accepted.
REQ-028 out_valid[i], once high, SHALL stay high with stable out_data until the channel-i transfer (no retraction).
REQ-029 Beats SHALL leave in the same order they were accepted; none SHALL be duplicated or lost except per REQ-025.

Reset
REQ-030 While rst_n = 0 at a rising edge: FSM to EMPTY, held data and held sel to 0, drop_count to 0, drop_pulse to 0.
REQ-031 Post-reset outputs: out_valid = 0, in_ready = 1, out_data = 0, drop_pulse = 0, drop_count = 0.
REQ-032 Reset asserted while FULL SHALL discard the held beat without a downstream transfer.
REQ-033 in_ready SHALL be 0 in any cycle where rst_n = 0.

Verification
REQ-034 N=4, DWIDTH=8: in_data=0xA5, in_sel=2, out_ready=4'b1111 -> out_valid=4'b0100, out_data[2]=0xA5 one cycle later, then EMPTY.
REQ-035 N=4: back-to-back beats sel 0,1,3,2 with out_ready all 1 -> out_valid 0001,0010,1000,0100 on consecutive cycles, in_ready held 1.
REQ-036 N=4: load sel=1 data 0x3C, hold out_ready[1]=0 for 5 cycles -> in_ready=0, out_valid=0010, out_data stable 0x3C throughout; release -> transfer in that cycle.
REQ-037 N=3: beat with in_sel=3 -> no out_valid, drop_pulse=1 for one cycle, drop_count=1; 260 illegal beats -> drop_count=255.
REQ-038 FULL with sel=0 and out_ready=0, drive rst_n=0 one cycle -> out_valid=0, in_ready=1, out_data=0 after the edge.
REQ-039 Formal: every accepted legal beat with sel=k appears exactly once on channel k with identical data, and $onehot0(out_valid) holds in every cycle.

Source files
------------

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux
// Brief    : One-deep registered demux steering a valid/ready stream to one of
//            N_OUTPUTS channels; beats with an out-of-range select are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux #(
  parameter int N_OUTPUTS = 2,
  parameter int DWIDTH    = 8,
  localparam int SW       = $clog2(N_OUTPUTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic [SW-1:0]        in_sel,
  output logic [N_OUTPUTS-1:0] out_valid,
  input  logic [N_OUTPUTS-1:0] out_ready,
  output logic [DWIDTH-1:0]    out_data [N_OUTPUTS],
  output logic                 drop_pulse,
  output logic [7:0]           drop_count
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [7:0] c_DROP_MAX = 8'hFF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_data;
  logic [SW-1:0]     r_sel;
  logic              r_drop_pulse;
  logic [7:0]        r_drop_count;

  logic w_sel_legal;
  logic w_out_xfer;
  logic w_in_xfer;
  logic w_load;
  logic w_drop;

  // in_ready is a function of held state, out_ready and reset only.
  assign w_out_xfer  = (r_state == ST_FULL) && out_ready[r_sel];
  assign in_ready    = rst_n && ((r_state == ST_EMPTY) || out_ready[r_sel]);
  assign w_sel_legal = int'(in_sel) < N_OUTPUTS;
  assign w_in_xfer   = in_valid && in_ready;
  assign w_load      = w_in_xfer && w_sel_legal;
  assign w_drop      = w_in_xfer && !w_sel_legal;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_load)          w_state_nxt = ST_FULL;
        else if (w_out_xfer) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_data       <= '0;
      r_sel        <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_drop_pulse <= w_drop;
      if (w_load) begin
        r_data <= in_data;
        r_sel  <= in_sel;
      end
      if (w_drop && (r_drop_count != c_DROP_MAX)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_OUTPUTS; i++) begin
      out_valid[i] = (r_state == ST_FULL) && (r_sel == SW'(i));
    end
  end

  // Payload is broadcast; out_valid alone says which channel owns it.
  generate
    for (genvar gi = 0; gi < N_OUTPUTS; gi++) begin : g_bcast
      assign out_data[gi] = r_data;
    end
  endgenerate

  assign drop_pulse = r_drop_pulse;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux
// Brief    : Scoreboard bench for stream_demux; a 4-channel and a 3-channel
//            instance share stimulus, one is observed at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [1:0] in_sel    = '0;
  logic [7:0] in_data   = '0;
  logic [3:0] out_ready = '0;
  logic       phase3    = 1'b0;

  logic       rdy4, rdy3, dp4, dp3;
  logic [3:0] ov4;
  logic [2:0] ov3;
  logic [7:0] od4 [4];
  logic [7:0] od3 [3];
  logic [7:0] dc4, dc3;

  stream_demux #(.N_OUTPUTS(4), .DWIDTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~phase3), .in_ready(rdy4),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .drop_pulse(dp4), .drop_count(dc4)
  );

  stream_demux #(.N_OUTPUTS(3), .DWIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & phase3), .in_ready(rdy3),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov3), .out_ready(out_ready[2:0]),
    .out_data(od3), .drop_pulse(dp3), .drop_count(dc3)
  );

  logic       m_ready, m_pulse;
  logic [3:0] m_valid;
  logic [7:0] m_cnt;
  assign m_ready = phase3 ? rdy3 : rdy4;
  assign m_valid = phase3 ? {1'b0, ov3} : ov4;
  assign m_pulse = phase3 ? dp3 : dp4;
  assign m_cnt   = phase3 ? dc3 : dc4;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t q[$];
  int    n_vec   = 0;
  int    n_err   = 0;
  logic  acc_ill = 1'b0;

  function automatic int nout();
    return phase3 ? 3 : 4;
  endfunction

  function automatic logic [7:0] chan_data(int k);
    if (phase3) return (k < 3) ? od3[k] : 8'h00;
    return od4[k];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input int s, input logic [7:0] d, input logic [3:0] ordy);
    @(negedge clk);
    rst_n = 1'b1; in_valid = v; in_sel = 2'(s); in_data = d; out_ready = ordy;
    #3;
    acc_ill = 1'b0;
    if (v && m_ready) begin
      if (s < nout()) q.push_back('{sel: 2'(s), data: d});
      else            acc_ill = 1'b1;
    end
  endtask

  task automatic rst_cyc(input logic [3:0] ordy);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = ordy;
    #3;
    acc_ill = 1'b0;
  endtask

  // Monitor: the queue holds accepted-but-undelivered beats (capacity one).
  initial begin : mon
    logic       rst_prev;
    int         exp_cnt;
    logic       exp_pulse;
    logic [3:0] exp_valid;
    logic       exp_ready;
    rst_prev = 1'b1;
    exp_cnt  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_prev) begin
        exp_cnt = 0; exp_pulse = 1'b0;
      end else begin
        exp_pulse = acc_ill;
        if (acc_ill && exp_cnt < 255) exp_cnt++;
      end
      check("drop_pulse", 32'(m_pulse), 32'(exp_pulse));
      check("drop_count", 32'(m_cnt), exp_cnt);
      exp_valid = (q.size() != 0) ? 4'(1 << q[0].sel) : 4'b0000;
      exp_ready = rst_n && ((q.size() == 0) || out_ready[q[0].sel]);
      check("out_valid", 32'(m_valid), 32'(exp_valid));
      check("in_ready", 32'(m_ready), 32'(exp_ready));
      if (q.size() != 0) begin
        for (int k = 0; k < nout(); k++) check("out_data", 32'(chan_data(k)), 32'(q[0].data));
      end
      if (!rst_n)                                   q.delete();
      else if (q.size() != 0 && out_ready[q[0].sel]) void'(q.pop_front());
      rst_prev = !rst_n;
    end
  end

  initial begin : drv
    int sels[4] = '{0, 1, 3, 2};
    rst_cyc(4'h0);
    rst_cyc(4'h0);

    cyc(1'b0, 0, 8'h00, 4'hF);
    check("rst_valid", 32'(ov4), 0);
    check("rst_ready", 32'(rdy4), 1);
    for (int k = 0; k < 4; k++) check("rst_data", 32'(od4[k]), 0);
    check("rst_count", 32'(dc4), 0);
    check("rst_pulse", 32'(dp4), 0);

    cyc(1'b1, 2, 8'hA5, 4'hF);
    cyc(1'b0, 0, 8'h00, 4'hF);
    check("single_valid", 32'(ov4), 32'h4);
    check("single_data", 32'(od4[2]), 32'hA5);
    cyc(1'b0, 0, 8'h00, 4'hF);
    check("single_empty", 32'(ov4), 0);

    for (int i = 0; i < 5; i++) begin
      cyc(i < 4, sels[i % 4], 8'(8'h10 + i), 4'hF);
      check("b2b_ready", 32'(rdy4), 1);
      if (i > 0) check("b2b_valid", 32'(ov4), 32'(1 << sels[i - 1]));
    end

    cyc(1'b1, 1, 8'h3C, 4'hF);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3, 8'hEE, 4'b1101);
      check("stall_ready", 32'(rdy4), 0);
      check("stall_valid", 32'(ov4), 32'h2);
      check("stall_data", 32'(od4[1]), 32'h3C);
    end
    cyc(1'b0, 0, 8'h00, 4'hF);
    check("release_valid", 32'(ov4), 32'h2);
    cyc(1'b0, 0, 8'h00, 4'hF);
    check("release_empty", 32'(ov4), 0);

    cyc(1'b1, 0, 8'h5A, 4'h0);
    cyc(1'b0, 0, 8'h00, 4'h0);
    check("pre_rst_valid", 32'(ov4), 32'h1);
    rst_cyc(4'h0);
    check("in_rst_ready", 32'(rdy4), 0);
    cyc(1'b0, 0, 8'h00, 4'h0);
    check("post_rst_valid", 32'(ov4), 0);
    check("post_rst_ready", 32'(rdy4), 1);
    check("post_rst_data", 32'(od4[0]), 0);

    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 4) != 0, int'($urandom % 4), 8'($urandom), 4'($urandom));
    end

    rst_cyc(4'h0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; phase3 = 1'b1;
    #3;
    acc_ill = 1'b0;

    cyc(1'b1, 3, 8'h77, 4'h7);
    cyc(1'b0, 0, 8'h00, 4'h7);
    check("drop_valid", 32'(ov3), 0);
    check("drop_pulse_hi", 32'(dp3), 1);
    check("drop_count_1", 32'(dc3), 1);
    cyc(1'b0, 0, 8'h00, 4'h7);
    check("drop_pulse_lo", 32'(dp3), 0);

    cyc(1'b1, 1, 8'h11, 4'h7);
    cyc(1'b1, 3, 8'h22, 4'h7);
    cyc(1'b0, 0, 8'h00, 4'h7);
    check("drop_full_empty", 32'(ov3), 0);

    for (int i = 0; i < 260; i++) cyc(1'b1, 3, 8'($urandom), 4'($urandom));
    cyc(1'b0, 0, 8'h00, 4'h7);
    check("drop_saturate", 32'(dc3), 255);

    rst_cyc(4'h0);
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 4) != 0, int'($urandom % 4), 8'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 8'h00, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
